// File: rtl/pcpi_pkg.sv
// Shared PCPI definitions: initiator FSM states, MUL/DIV opcode fields and
// the default claim timeout, used by the issue controller and the responders.
package pcpi_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      BUSY,
      RESP
   } pcpi_state_e;

   localparam logic [6:0] OPC_OP    = 7'h33;
   localparam logic [6:0] F7_MULDIV = 7'h01;

   localparam logic [2:0] DIV  = 3'd4;
   localparam logic [2:0] DIVU = 3'd5;
   localparam logic [2:0] REM  = 3'd6;
   localparam logic [2:0] REMU = 3'd7;

   localparam int unsigned PCPI_TIMEOUT = 16;

   // Divide/remainder group: OP opcode, MULDIV funct7, funct3 in 4..7.
   function automatic logic pcpi_is_div(input logic [31:0] insn);
      return (insn[6:0] == OPC_OP) && (insn[31:25] == F7_MULDIV) && insn[14];
   endfunction

endpackage

// File: rtl/pcpi_issue_ctrl_if.sv
// PCPI bus between the core-side initiator (master) and the coprocessors (slave).
interface pcpi_issue_ctrl_if;

   logic        pcpi_valid;
   logic [31:0] pcpi_insn;
   logic [31:0] pcpi_rs1;
   logic [31:0] pcpi_rs2;
   logic        pcpi_wr;
   logic [31:0] pcpi_rd;
   logic        pcpi_wait;
   logic        pcpi_ready;

   modport master (
      output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
      input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
   );

   modport slave (
      input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
      output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
   );

endinterface

// File: rtl/pcpi_timeout_ctr.sv
// Claim timeout counter: counts unclaimed ISSUE cycles, expire marks the last one.
module pcpi_timeout_ctr #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int unsigned    CW   = $clog2(TIMEOUT);
   localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CW'(1);
      end
   end

   assign expire = (count == LAST);

endmodule

// File: rtl/pcpi_issue_ctrl.sv
// Core-side PCPI initiator: issues one instruction to the coprocessors, waits for
// a claim/result, flags unclaimed instructions illegal and returns the response.
module pcpi_issue_ctrl
   import pcpi_pkg::*;
#(
   parameter int unsigned TIMEOUT = PCPI_TIMEOUT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,

   input  logic              req_valid,
   output logic              req_ready,
   input  logic [31:0]       req_insn,
   input  logic [31:0]       req_rs1,
   input  logic [31:0]       req_rs2,

   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_wr,
   output logic [31:0]       rsp_rd,
   output logic              rsp_illegal,

   pcpi_issue_ctrl_if.master pcpi
);

   pcpi_state_e state, state_next;

   logic        capture_req;
   logic        capture_rsp;
   logic        capture_illegal;
   logic        ctr_clear;
   logic        ctr_enable;
   logic        expire;

   logic [31:0] insn_q;
   logic [31:0] rs1_q;
   logic [31:0] rs2_q;

   pcpi_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .clear  (ctr_clear),
      .enable (ctr_enable),
      .expire (expire)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next      = state;
      capture_req     = 1'b0;
      capture_rsp     = 1'b0;
      capture_illegal = 1'b0;
      ctr_clear       = 1'b0;
      ctr_enable      = 1'b0;

      if (flush) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  capture_req = 1'b1;
                  ctr_clear   = 1'b1;
                  state_next  = ISSUE;
               end
            end
            // ready beats wait beats timeout, so a responder finishing on the
            // last allowed cycle still gets its result through.
            ISSUE: begin
               if (pcpi.pcpi_ready) begin
                  capture_rsp = 1'b1;
                  state_next  = RESP;
               end else if (pcpi.pcpi_wait) begin
                  state_next = BUSY;
               end else if (expire) begin
                  capture_illegal = 1'b1;
                  state_next      = RESP;
               end else begin
                  ctr_enable = 1'b1;
               end
            end
            BUSY: begin
               if (pcpi.pcpi_ready) begin
                  capture_rsp = 1'b1;
                  state_next  = RESP;
               end else if (!pcpi.pcpi_wait) begin
                  ctr_clear  = 1'b1;
                  state_next = ISSUE;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state_next = IDLE;
               end
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         insn_q      <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         rsp_wr      <= 1'b0;
         rsp_rd      <= '0;
         rsp_illegal <= 1'b0;
      end else begin
         if (capture_req) begin
            insn_q <= req_insn;
            rs1_q  <= req_rs1;
            rs2_q  <= req_rs2;
         end
         if (capture_rsp) begin
            rsp_wr      <= pcpi.pcpi_wr;
            rsp_rd      <= pcpi.pcpi_rd;
            rsp_illegal <= 1'b0;
         end else if (capture_illegal) begin
            rsp_wr      <= 1'b0;
            rsp_rd      <= '0;
            rsp_illegal <= 1'b1;
         end
      end
   end

   assign req_ready       = (state == IDLE);
   assign rsp_valid       = (state == RESP);
   assign pcpi.pcpi_valid = (state == ISSUE) || (state == BUSY);
   assign pcpi.pcpi_insn  = insn_q;
   assign pcpi.pcpi_rs1   = rs1_q;
   assign pcpi.pcpi_rs2   = rs2_q;

endmodule

// File: tb/tb_pcpi_issue_ctrl.sv
// Bench for pcpi_issue_ctrl: scripted and random responder timings checked
// against a transaction-level model of claim, timeout and response rules.
module tb_pcpi_issue_ctrl;
   import pcpi_pkg::*;

   localparam int unsigned T = 16;

   typedef struct {
      logic [31:0] insn;
      logic [31:0] rs1;
      logic [31:0] rs2;
      bit          claim;       // a responder will ever answer this op
      int unsigned c0;          // unclaimed cycles before wait
      int unsigned w;           // cycles of pcpi_wait
      int unsigned g;           // quiet cycles after wait before ready
      bit          wait_at_rdy; // pcpi_wait high together with pcpi_ready
      logic        wr;
      logic [31:0] rd;
      int unsigned bp;          // rsp_ready held low this many extra cycles
   } op_t;

   logic        clk = 1'b0;
   logic        reset, flush;
   logic        req_valid, req_ready;
   logic [31:0] req_insn, req_rs1, req_rs2;
   logic        rsp_valid, rsp_ready, rsp_wr, rsp_illegal;
   logic [31:0] rsp_rd;

   pcpi_issue_ctrl_if pcpi_bus ();

   pcpi_issue_ctrl #(
      .TIMEOUT (T)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_insn    (req_insn),
      .req_rs1     (req_rs1),
      .req_rs2     (req_rs2),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_wr      (rsp_wr),
      .rsp_rd      (rsp_rd),
      .rsp_illegal (rsp_illegal),
      .pcpi        (pcpi_bus)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   logic [31:0] last_rd;
   logic        last_wr, last_illegal;
   int unsigned last_vcount;
   logic [31:0] held_rd = '0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] hs();
      return {29'b0, pcpi_bus.pcpi_valid, rsp_valid, req_ready};
   endfunction

   function automatic logic [31:0] b32(input logic b);
      return {31'b0, b};
   endfunction

   // RISC-V M-extension divide/remainder semantics, including /0 and overflow.
   function automatic logic [31:0] ref_div(input logic [31:0] insn, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [2:0] f3;
      int sa, sb;
      logic ovf;
      f3  = insn[14:12];
      sa  = a;
      sb  = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f3)
         DIV:     return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
         DIVU:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
         REM:     return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Outcome of an op: legal/illegal and how many cycles pcpi_valid stays high.
   function automatic void model(input op_t op, output bit legal, output int unsigned hi);
      if (!op.claim) begin
         legal = 0; hi = T;
      end else if (op.w == 0) begin
         if (op.c0 + op.g + 1 <= T) begin legal = 1; hi = op.c0 + op.g + 1; end
         else begin legal = 0; hi = T; end
      end else if (op.c0 + 1 > T) begin
         legal = 0; hi = T;
      end else if (op.g <= T) begin
         legal = 1; hi = op.c0 + op.w + op.g + 1;
      end else begin
         legal = 0; hi = op.c0 + op.w + 1 + T;
      end
   endfunction

   function automatic op_t mk_div(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b,
                                  input int unsigned c0, input int unsigned w, input int unsigned g,
                                  input bit war, input int unsigned bp);
      op_t op;
      op.insn = insn; op.rs1 = a; op.rs2 = b; op.claim = 1;
      op.c0 = c0; op.w = w; op.g = g; op.wait_at_rdy = war;
      op.wr = 1'b1; op.rd = ref_div(insn, a, b); op.bp = bp;
      return op;
   endfunction

   task automatic idle_pcpi_inputs();
      pcpi_bus.pcpi_wait  = 1'b0;
      pcpi_bus.pcpi_ready = 1'b0;
      pcpi_bus.pcpi_wr    = 1'b0;
      pcpi_bus.pcpi_rd    = '0;
   endtask

   // Starts just after a negedge with the DUT idle; ends likewise.
   task automatic run_op(input op_t op, input bit chain, input op_t nxt);
      bit          legal;
      int unsigned hi, r, span, last;
      logic        exp_wr, exp_ill;
      logic [31:0] exp_rd, rnd;
      bit          w_sig, r_sig;

      model(op, legal, hi);
      exp_wr  = legal ? op.wr : 1'b0;
      exp_rd  = legal ? op.rd : 32'h0;
      exp_ill = !legal;
      r       = op.c0 + op.w + op.g;
      span    = (op.claim && (r + 1 > hi)) ? r + 1 : hi;
      last    = span + op.bp;
      last_vcount = 0;

      check_eq("req_ready_idle", hs(), 32'h1);
      req_valid = 1'b1; req_insn = op.insn; req_rs1 = op.rs1; req_rs2 = op.rs2;
      @(negedge clk);
      req_valid = 1'b0; req_insn = $urandom; req_rs1 = $urandom; req_rs2 = $urandom;

      for (int unsigned k = 0; k <= last; k++) begin
         if (pcpi_bus.pcpi_valid) last_vcount++;
         if (k < hi) begin
            check_eq("issue_hs", hs(), 32'h4);
            if (k == 0 || k == hi - 1) begin
               check_eq("pcpi_insn", pcpi_bus.pcpi_insn, op.insn);
               check_eq("pcpi_rs1", pcpi_bus.pcpi_rs1, op.rs1);
               check_eq("pcpi_rs2", pcpi_bus.pcpi_rs2, op.rs2);
            end
         end else begin
            if (k == hi) begin
               last_rd = rsp_rd; last_wr = rsp_wr; last_illegal = rsp_illegal;
            end
            check_eq("resp_hs", hs(), 32'h2);
            check_eq("rsp_wr", b32(rsp_wr), b32(exp_wr));
            check_eq("rsp_rd", rsp_rd, exp_rd);
            check_eq("rsp_illegal", b32(rsp_illegal), b32(exp_ill));
         end
         w_sig = 0; r_sig = 0;
         if (op.claim) begin
            if (k >= op.c0 && k < op.c0 + op.w) w_sig = 1;
            if (k == r) begin r_sig = 1; w_sig = op.wait_at_rdy; end
         end
         rnd = $urandom;
         pcpi_bus.pcpi_wait  = w_sig;
         pcpi_bus.pcpi_ready = r_sig;
         pcpi_bus.pcpi_wr    = r_sig ? op.wr : rnd[0];
         pcpi_bus.pcpi_rd    = r_sig ? op.rd : $urandom;
         rsp_ready = (k == last);
         if (k == last && chain) begin
            req_valid = 1'b1; req_insn = nxt.insn; req_rs1 = nxt.rs1; req_rs2 = nxt.rs2;
         end
         @(negedge clk);
      end
      rsp_ready = 1'b0;
      idle_pcpi_inputs();
      check_eq("valid_len", last_vcount, hi);
      check_eq("back_to_idle", hs(), 32'h1);
      held_rd = exp_rd;
   endtask

   op_t none, o1, o2, ops[41];
   logic [31:0] rnd_a;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      none = mk_div(32'h0, 32'h0, 32'h1, 0, 0, 0, 0, 0);
      reset = 1'b1; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
      req_insn = '0; req_rs1 = '0; req_rs2 = '0;
      idle_pcpi_inputs();
      repeat (3) @(negedge clk);
      check_eq("rst_hs", hs(), 32'h1);
      check_eq("rst_rsp_rd", rsp_rd, 32'h0);
      check_eq("rst_rsp_flags", {30'b0, rsp_wr, rsp_illegal}, 32'h0);
      check_eq("rst_pcpi_insn", pcpi_bus.pcpi_insn, 32'h0);
      reset = 1'b0;
      @(negedge clk);

      // DIV -7/2 through a multi-cycle divider
      run_op(mk_div(32'h0200_4033, 32'hFFFF_FFF9, 32'd2, 0, 3, 0, 0, 0), 0, none);
      check_eq("div_rd", last_rd, 32'hFFFF_FFFD);
      check_eq("div_flags", {30'b0, last_wr, last_illegal}, 32'h2);

      // REM then DIVU with req_valid held
      o1 = mk_div(32'h0200_6033, 32'hFFFF_FFF9, 32'd2, 1, 4, 0, 0, 0);
      o2 = mk_div(32'h0200_5033, 32'd7, 32'd0, 0, 2, 0, 0, 0);
      run_op(o1, 1, o2);
      check_eq("rem_rd", last_rd, 32'hFFFF_FFFF);
      run_op(o2, 0, none);
      check_eq("divu0_rd", last_rd, 32'hFFFF_FFFF);

      // Unclaimed instruction times out
      o1 = none; o1.insn = 32'h0000_000B; o1.claim = 0;
      run_op(o1, 0, none);
      check_eq("unclaimed_len", last_vcount, 32'd16);
      check_eq("unclaimed_flags", {30'b0, last_wr, last_illegal}, 32'h1);
      check_eq("unclaimed_rd", last_rd, 32'h0);

      // ready+wait on the final ISSUE cycle: ready wins over timeout
      run_op(mk_div(32'h0200_4033, 32'd20, 32'd5, 15, 0, 0, 1, 0), 0, none);
      check_eq("collide_len", last_vcount, 32'd16);
      check_eq("collide_illegal", b32(last_illegal), 32'h0);
      check_eq("collide_rd", last_rd, 32'd4);

      // Backpressure on DIVU 100/7
      run_op(mk_div(32'h0200_5033, 32'd100, 32'd7, 0, 5, 0, 0, 5), 0, none);
      check_eq("bp_rd", last_rd, 32'd14);

      // Flush mid-divide, then stray responder strobes in IDLE
      req_valid = 1'b1; req_insn = 32'h0200_5033; req_rs1 = 32'd50; req_rs2 = 32'd5;
      @(negedge clk);
      req_valid = 1'b0;
      pcpi_bus.pcpi_wait = 1'b1;
      @(negedge clk);
      check_eq("flush_busy_hs", hs(), 32'h4);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check_eq("flush_idle_hs", hs(), 32'h1);
      pcpi_bus.pcpi_wait = 1'b0; pcpi_bus.pcpi_ready = 1'b1;
      pcpi_bus.pcpi_wr = 1'b1; pcpi_bus.pcpi_rd = 32'd10;
      @(negedge clk);
      idle_pcpi_inputs();
      check_eq("stray_ready_hs", hs(), 32'h1);
      check_eq("stray_ready_rd", rsp_rd, held_rd);
      flush = 1'b1; req_valid = 1'b1; req_insn = 32'h0200_5033;
      @(negedge clk);
      flush = 1'b0; req_valid = 1'b0;
      check_eq("flush_beats_req", hs(), 32'h1);
      run_op(mk_div(32'h0200_5033, 32'd9, 32'd3, 0, 2, 0, 0, 1), 0, none);
      check_eq("after_flush_rd", last_rd, 32'd3);

      // Reset mid-ISSUE
      req_valid = 1'b1; req_insn = 32'hA5A5_000B; req_rs1 = 32'h1234; req_rs2 = 32'h5678;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("pre_reset_hs", hs(), 32'h4);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_eq("mid_rst_hs", hs(), 32'h1);
      check_eq("mid_rst_rsp", {30'b0, rsp_wr, rsp_illegal}, 32'h0);
      check_eq("mid_rst_rd", rsp_rd, 32'h0);
      check_eq("mid_rst_insn", pcpi_bus.pcpi_insn, 32'h0);
      check_eq("mid_rst_rs", pcpi_bus.pcpi_rs1 | pcpi_bus.pcpi_rs2, 32'h0);
      held_rd = '0;

      // Random ops and responder timings
      for (int i = 0; i < 41; i++) begin
         int unsigned kind;
         kind  = $urandom_range(0, 2);
         rnd_a = $urandom;
         if (kind == 0) begin
            ops[i] = mk_div({F7_MULDIV, rnd_a[24:15], 1'b1, rnd_a[13:0], OPC_OP}, $urandom,
                            ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom,
                            0, 0, 0, 0, 0);
            if ($urandom_range(0, 7) == 0) begin
               ops[i].rs1 = 32'h8000_0000; ops[i].rs2 = 32'hFFFF_FFFF;
               ops[i].rd  = ref_div(ops[i].insn, ops[i].rs1, ops[i].rs2);
            end
         end else begin
            ops[i] = none;
            ops[i].insn  = {rnd_a[31:7], (kind == 1) ? 7'h0B : 7'h2B};
            ops[i].claim = (kind == 1);
            ops[i].wr    = rnd_a[3];
            ops[i].rd    = $urandom;
         end
         ops[i].c0 = $urandom_range(0, 17);
         ops[i].w  = $urandom_range(0, 5);
         ops[i].g  = $urandom_range(0, 18);
         ops[i].wait_at_rdy = ($urandom_range(0, 1) == 1);
         ops[i].bp = $urandom_range(0, 4);
      end
      for (int i = 0; i < 40; i++) begin
         run_op(ops[i], ($urandom_range(0, 1) == 1), ops[i + 1]);
      end
      if (req_valid) run_op(ops[40], 0, none);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
